// File: rtl/pll_reset_sequencer_if.sv
// Lock/reset bundle between the PLL supervisor and its consumers.
// master = sequencer side, slave = PLL/system side.
`timescale 1ns/1ps
interface pll_reset_sequencer_if;
  logic       lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  modport master (
    input  lock,
    output pll_reset,
    output sys_reset,
    output ready,
    output lock_loss_cnt,
    output retry_cnt,
    output state
  );

  modport slave (
    output lock,
    input  pll_reset,
    input  sys_reset,
    input  ready,
    input  lock_loss_cnt,
    input  retry_cnt,
    input  state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor / system reset sequencer on the reference clock.
// Define PLL_RETRY_EN for the PLL_RST state and lock-timeout retries.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int PLL_RST_CYCLES      = 50
) (
  input logic                   clk,
  input logic                   reset,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int MAX_A =
    (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
    LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_B =
    (LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES) ?
    LOCK_TIMEOUT_CYCLES : PLL_RST_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] STABLE_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(RESET_HOLD_CYCLES - 1);

`ifdef PLL_RETRY_EN
  localparam logic [CW-1:0] TIMEOUT_LAST =
    CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PLLRST_LAST =
    CW'(PLL_RST_CYCLES - 1);
  localparam state_e RST_STATE = PLL_RST;
`else
  localparam state_e RST_STATE = WAIT_LOCK;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             loss_q, loss_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
`ifdef PLL_RETRY_EN
  logic [3:0]             retry_q, retry_d;
  logic                   pll_rst_q, pll_rst_d;
`endif

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.lock};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
`ifdef PLL_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      PLL_RST: begin
`ifdef PLL_RETRY_EN
        if (cnt_q == PLLRST_LAST) state_d = WAIT_LOCK;
`else
        state_d = WAIT_LOCK;
`endif
      end
      WAIT_LOCK: begin
        // lock is checked first so it beats a coincident timeout
        if (lock_s) begin
          state_d = STABLE;
`ifdef PLL_RETRY_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
`endif
        end
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = RST_STATE;
    endcase

    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q) cnt_d = '0;

    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
`ifdef PLL_RETRY_EN
    pll_rst_d = (state_d == PLL_RST);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      loss_q    <= '0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
`ifdef PLL_RETRY_EN
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
`ifdef PLL_RETRY_EN
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
`endif
    end
  end

  assign bus.state         = state_q;
  assign bus.sys_reset     = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_q;
`ifdef PLL_RETRY_EN
  assign bus.pll_reset     = pll_rst_q;
  assign bus.retry_cnt     = retry_q;
`else
  assign bus.pll_reset     = 1'b0;
  assign bus.retry_cnt     = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer (S=2, STABLE=8, HOLD=4,
// TIMEOUT=20, PLL_RST=3); expectations keyed to edges after reset release.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

`ifdef PLL_RETRY_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam logic [2:0] S_PR  = 3'd0;
  localparam logic [2:0] S_WL  = 3'd1;
  localparam logic [2:0] S_ST  = 3'd2;
  localparam logic [2:0] S_HO  = 3'd3;
  localparam logic [2:0] S_RUN = 3'd4;
  localparam logic [2:0] S_RST = (OFF == 1) ? S_PR : S_WL;

  typedef struct {
    int          e;
    logic [17:0] v;
    string       name;
  } item_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    edge_n = 0;
  int    errors = 0;
  int    checks = 0;
  item_t sb[$];

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .SYNC_STAGES(2),
    .LOCK_STABLE_CYCLES(8),
    .RESET_HOLD_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(20),
    .PLL_RST_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else edge_n <= edge_n + 1;
  end

  task automatic expect_at(input int e, input logic [2:0] s,
                           input int loss, input int rt,
                           input string nm);
    item_t it;
    logic [7:0] l8;
    logic [3:0] r4;
    l8 = 8'(loss);
    r4 = 4'(rt);
    it.e = e;
    it.v = {s, s == S_PR, s != S_RUN, s == S_RUN, l8, r4};
    it.name = nm;
    sb.push_back(it);
  endtask

  // monitor: compares at each negedge and right after reset assertion
  initial begin
    item_t it;
    logic [17:0] act;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      act = {bus.state, bus.pll_reset, bus.sys_reset, bus.ready,
             bus.lock_loss_cnt, bus.retry_cnt};
      while (sb.size() > 0 && sb[0].e <= edge_n) begin
        it = sb.pop_front();
        checks++;
        if (it.e < edge_n) begin
          errors++;
          $display("FAIL %s: edge %0d missed, now edge %0d",
                   it.name, it.e, edge_n);
        end else if (act !== it.v) begin
          errors++;
          $display("FAIL %s @edge %0d: got %h want %h",
                   it.name, it.e, act, it.v);
        end
      end
    end
  end

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() > 0 && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d items left, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input string nm);
    drain();
    #2;
    reset = 1'b1;
    expect_at(0, S_RST, 0, 0, nm);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic acquire();
    expect_at(2, S_RST, 0, 0, "acq_e2");
`ifdef PLL_RETRY_EN
    expect_at(3, S_WL, 0, 0, "acq_wl");
`endif
    expect_at(3 + OFF, S_ST, 0, 0, "acq_stable");
    expect_at(10 + OFF, S_ST, 0, 0, "acq_stable_end");
    expect_at(11 + OFF, S_HO, 0, 0, "acq_hold");
    expect_at(14 + OFF, S_HO, 0, 0, "acq_hold_end");
    expect_at(15 + OFF, S_RUN, 0, 0, "acq_run");
    wait_edge(15 + OFF);
  endtask

  initial begin
    int e;
    int n;
    int rt0;
    int rt1;
    bus.lock = 1'b1;
    expect_at(0, S_RST, 0, 0, "reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    acquire();

    // loss in RUN, then slow reacquire
    e = edge_n;
    bus.lock = 1'b0;
    expect_at(e + 2, S_RUN, 0, 0, "run_before_loss");
    expect_at(e + 3, S_WL, 1, 0, "run_loss");
    wait_edge(e + 3);
    bus.lock = 1'b1;
    expect_at(e + 5, S_WL, 1, 0, "relock_wait");
    expect_at(e + 6, S_ST, 1, 0, "relock_stable");
    expect_at(e + 14, S_HO, 1, 0, "relock_hold");
    expect_at(e + 18, S_RUN, 1, 0, "relock_run");
    wait_edge(e + 18);

    // loss in RUN, then a one-cycle glitch while STABLE
    e = edge_n;
    expect_at(e + 3, S_WL, 2, 0, "loss2");
    expect_at(e + 4, S_ST, 2, 0, "g_stable");
    expect_at(e + 7, S_ST, 2, 0, "g_pre");
    expect_at(e + 8, S_WL, 2, 0, "g_glitch");
    expect_at(e + 9, S_ST, 2, 0, "g_stable2");
    expect_at(e + 16, S_ST, 2, 0, "g_stable_end");
    expect_at(e + 17, S_HO, 2, 0, "g_hold");
    expect_at(e + 21, S_RUN, 2, 0, "g_run");
    bus.lock = 1'b0;
    wait_edge(e + 1);
    bus.lock = 1'b1;
    wait_edge(e + 5);
    bus.lock = 1'b0;
    wait_edge(e + 6);
    bus.lock = 1'b1;
    wait_edge(e + 21);

    // 298 more losses: counter saturates at 255
    n = 2;
    for (int i = 0; i < 298; i++) begin
      e = edge_n;
      n = (n == 255) ? 255 : n + 1;
      expect_at(e + 3, S_WL, n, 0, "sat_loss");
      expect_at(e + 16, S_RUN, n, 0, "sat_run");
      bus.lock = 1'b0;
      wait_edge(e + 1);
      bus.lock = 1'b1;
      wait_edge(e + 16);
    end

    // no lock: retry pulses every 23 cycles, retry_cnt saturates
    bus.lock = 1'b0;
    do_reset("reset_clears_loss");
    expect_at(2, S_RST, 0, 0, "nolock_e2");
`ifdef PLL_RETRY_EN
    expect_at(3, S_WL, 0, 0, "nolock_wl");
`endif
    for (int k = 0; k <= 16; k++) begin
      rt0 = (OFF == 1) ? ((k > 15) ? 15 : k) : 0;
      rt1 = (OFF == 1) ? ((k + 1 > 15) ? 15 : k + 1) : 0;
      expect_at(22 + 23 * k, S_WL, 0, rt0, "retry_pre");
      expect_at(23 + 23 * k, (OFF == 1) ? S_PR : S_WL, 0, rt1,
                "retry_rise");
      expect_at(25 + 23 * k, (OFF == 1) ? S_PR : S_WL, 0, rt1,
                "retry_high");
      expect_at(26 + 23 * k, S_WL, 0, rt1, "retry_fall");
    end
    wait_edge(26 + 23 * 16);

    // lock_s rises with the 20th WAIT_LOCK cycle: lock wins
    do_reset("reset_clears_retry");
    expect_at(2, S_RST, 0, 0, "tie_e2");
`ifdef PLL_RETRY_EN
    expect_at(3, S_WL, 0, 0, "tie_wl");
`endif
    expect_at(22, S_WL, 0, 0, "tie_pre");
    expect_at(23, S_ST, 0, 0, "tie_stable");
    expect_at(24, S_ST, 0, 0, "tie_no_pulse");
    expect_at(31, S_HO, 0, 0, "tie_hold");
    expect_at(32, S_HO, 0, 0, "tie_hold2");
    wait_edge(20);
    bus.lock = 1'b1;
    wait_edge(32);

    // async reset in HOLD, then full restart
    do_reset("async_reset_hold");
    acquire();

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout, %0d items pending", sb.size());
    $fatal(1, "watchdog");
  end

endmodule
